// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage.
//   fetch_state_e : fetch sequencer states (FETCH / WAIT / DROP)
//   if_id_t       : IF/ID register payload {valid, pc, inst}
//   word_align()  : clears the two low address bits
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_C = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_C = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel.
//   req/addr   : fetch request and word-aligned address (master drives)
//   gnt        : request accepted this cycle (req & gnt = handshake)
//   rvalid     : response valid, at least one cycle after gnt
//   rdata      : fetched instruction word
interface fetch_stage_if;
  import pipe_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an IF/ID payload that arrives while ID is stalled.
//   clk, rst_n   : clock, async active-low reset
//   push/pop     : load din / release the entry
//   flush        : discard the entry (wins over push/pop)
//   din, dout    : payload in / registered payload out
//   full         : entry occupied (registered)
//   full_next_c  : occupancy after the coming edge (combinational)
module fetch_skid_buf
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  if_id_t din,
  output if_id_t dout,
  output logic   full,
  output logic   full_next_c
);

  if_id_t entry_q;
  logic   full_q;

  // Next occupancy: flush beats push, push beats pop.
  always_comb begin
    full_next_c = full_q;
    if (flush) begin
      full_next_c = 1'b0;
    end else if (push) begin
      full_next_c = 1'b1;
    end else if (pop) begin
      full_next_c = 1'b0;
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q <= full_next_c;
      if (push && !flush) begin
        entry_q <= din;
      end
    end
  end

  assign dout = entry_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request
// outstanding, writes {pc, inst, valid} into IF/ID, absorbs ID stalls with a
// one-entry skid buffer and kills wrong-path fetches on an EX redirect.
// Optional build macro: FETCH_MISALIGN_CHECK_EN -- a redirect to a target that
// is not 4-byte aligned raises sticky o_misalign and halts fetch until the next
// aligned redirect; without it the target low bits are silently cleared.
// Ports:
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_pc_sel, i_alu_data   : EX redirect strobe and target
//   i_id_stall             : ID cannot accept, hold IF/ID
//   imem (master)          : req/addr out, gnt/rvalid/rdata in
//   o_if_valid/pc/inst     : IF/ID register (inst = NOP_INST when invalid)
//   o_misalign             : misaligned-redirect flag (0 unless macro defined)
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_C,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_C
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pc_sel,
  input  logic [XLEN-1:0]  i_alu_data,
  input  logic             i_id_stall,
  fetch_stage_if.master    imem,
  output logic             o_if_valid,
  output logic [XLEN-1:0]  o_if_pc,
  output logic [XLEN-1:0]  o_if_inst,
  output logic             o_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            req_q, req_d;
  if_id_t          ifid_q, ifid_d;
  logic            halt_q, halt_d;
  logic            bad_target;
  logic            fire;
  logic            deliver;
  if_id_t          deliver_pkt;
  logic            skid_push, skid_pop, skid_flush;
  logic            skid_full, skid_full_next;
  if_id_t          skid_dout;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_target = (i_alu_data[1:0] != 2'b00);

  // Sticky misalign / fetch-halt flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign o_misalign = halt_q;
`else
  assign bad_target = 1'b0;
  assign halt_q     = 1'b0;
  assign o_misalign = 1'b0;
`endif

  fetch_skid_buf u_skid (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .push        (skid_push),
    .pop         (skid_pop),
    .flush       (skid_flush),
    .din         (deliver_pkt),
    .dout        (skid_dout),
    .full        (skid_full),
    .full_next_c (skid_full_next)
  );

  // Next-state, PC and IF/ID update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    halt_d      = halt_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;
    fire        = req_q & imem.gnt;
    // A response coinciding with a redirect belongs to the killed path.
    deliver     = (state_q == WAIT) & imem.rvalid & ~i_pc_sel;
    deliver_pkt = '{valid: 1'b1, pc: req_pc_q, inst: imem.rdata};

    unique case (state_q)
      FETCH: if (fire) state_d = i_pc_sel ? DROP : WAIT;
      // A redirect while waiting only needs DROP if the response is still owed.
      WAIT: begin
        if (imem.rvalid) begin
          state_d = FETCH;
        end else if (i_pc_sel) begin
          state_d = DROP;
        end
      end
      DROP: if (imem.rvalid) state_d = FETCH;
      default: state_d = FETCH;
    endcase

    if (i_pc_sel) begin
      halt_d = bad_target;
      if (!bad_target) begin
        pc_d = word_align(i_alu_data);
      end
    end else if (fire) begin
      pc_d = pc_q + XLEN'(4);
    end

    // Redirect overrides stall; otherwise skid drains before new data lands.
    if (i_pc_sel) begin
      ifid_d     = '{valid: 1'b0, pc: ifid_q.pc, inst: NOP_INST};
      skid_flush = 1'b1;
    end else if (!ifid_q.valid || !i_id_stall) begin
      if (skid_full) begin
        ifid_d   = skid_dout;
        skid_pop = 1'b1;
      end else if (deliver) begin
        ifid_d = deliver_pkt;
      end else begin
        ifid_d = '{valid: 1'b0, pc: ifid_q.pc, inst: NOP_INST};
      end
    end else if (deliver) begin
      skid_push = 1'b1;
    end

    // Request register mirrors the coming state so req stays low in reset.
    req_d = (state_d == FETCH) & ~skid_full_next & ~halt_d;
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= FETCH;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= word_align(RESET_PC);
      req_q    <= 1'b0;
      ifid_q   <= '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      ifid_q  <= ifid_d;
      if (fire) begin
        req_pc_q <= pc_q;
      end
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = pc_q;
  assign o_if_valid = ifid_q.valid;
  assign o_if_pc    = ifid_q.pc;
  assign o_if_inst  = ifid_q.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural imem responder plus a
// program-order model of the instruction stream ID should consume.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_sel;
  logic [31:0] alu_data;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign;

  fetch_stage_if bus ();

  fetch_stage dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pc_sel   (pc_sel),
    .i_alu_data (alu_data),
    .i_id_stall (id_stall),
    .imem       (bus),
    .o_if_valid (if_valid),
    .o_if_pc    (if_pc),
    .o_if_inst  (if_inst),
    .o_misalign (misalign)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          consumed = 0;
  logic [31:0] exp_pc;
  bit          pend;
  int          wait_cnt;
  logic [31:0] pend_addr;
  int          gnt_pct, lat_min, lat_max;
  logic [31:0] grant_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  // One clock: drive inputs after negedge, check the consumer view, then
  // return #1 after the rising edge.
  task automatic cycle(input logic sel, input logic [31:0] tgt, input logic stall);
    logic rv, g;
    @(negedge clk);
    rv = pend && (wait_cnt == 0);
    g  = ($urandom_range(99) < gnt_pct);
    pc_sel     = sel;
    alu_data   = tgt;
    id_stall   = stall;
    bus.gnt    = g;
    bus.rvalid = rv;
    bus.rdata  = rv ? mem_word(pend_addr) : $urandom();
    if (bus.req) begin
      n_checks++;
      if (pend || bus.addr[1:0] != 2'b00)
        $display("FAIL req_protocol: outstanding=%0b addr=%h required no outstanding, aligned", pend, bus.addr);
      else n_pass++;
    end
    if (!if_valid) begin
      n_checks++;
      if (if_inst !== NOP) $display("FAIL nop_when_invalid: inst=%h required %h", if_inst, NOP);
      else n_pass++;
    end else if (!stall && !sel) begin
      n_checks++;
      if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc))
        $display("FAIL stream_order: pc=%h inst=%h required pc=%h inst=%h", if_pc, if_inst, exp_pc, mem_word(exp_pc));
      else n_pass++;
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (sel && !(MIS_EN && tgt[1:0] != 2'b00)) exp_pc = tgt & ~32'd3;
    if (rv) pend = 1'b0;
    else if (pend) wait_cnt--;
    if (bus.req && g) begin
      pend      = 1'b1;
      pend_addr = bus.addr;
      wait_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      grant_q.push_back(bus.addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; pc_sel = 1'b0; id_stall = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; alu_data = '0;
    pend = 1'b0; wait_cnt = 0; exp_pc = 32'h0; grant_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b0);
    // Asynchronous assertion mid-cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0; bus.gnt = 1'b0; bus.rvalid = 1'b0;
    #1;
    n_checks++; if (bus.req !== 1'b0) $display("FAIL reset_req: got %b required 0", bus.req); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", if_valid); else n_pass++;
    n_checks++; if (if_pc !== 32'h0) $display("FAIL reset_pc: got %h required 0", if_pc); else n_pass++;
    n_checks++; if (if_inst !== NOP) $display("FAIL reset_inst: got %h required %h", if_inst, NOP); else n_pass++;
    n_checks++; if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b required 0", misalign); else n_pass++;
    pend = 1'b0; exp_pc = 32'h0; grant_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0)
      $display("FAIL first_req: req=%b addr=%h required 1 / 0", bus.req, bus.addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    int c0;
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    c0 = consumed;
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0)
      $display("FAIL first_delivery: valid=%b pc=%h required 1 / 0", if_valid, if_pc);
    else n_pass++;
    repeat (22) cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (grant_q.size() < 8) $display("FAIL seq_grant_count: got %0d required >=8", grant_q.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < grant_q.size(); i++) begin
      n_checks++;
      if (grant_q[i] !== 32'(i * 4)) $display("FAIL seq_addr: got %h required %h", grant_q[i], 32'(i * 4));
      else n_pass++;
    end
    n_checks++;
    if (consumed - c0 < 8) $display("FAIL seq_consumed: got %0d required >=8", consumed - c0);
    else n_pass++;
  endtask

  task automatic test_slow_response();
    int c0;
    do_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    c0 = consumed;
    repeat (40) cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (grant_q.size() < 9 || grant_q.size() > 11)
      $display("FAIL slow_grant_count: got %0d required 9..11", grant_q.size());
    else n_pass++;
    for (int i = 0; i < grant_q.size(); i++) begin
      n_checks++;
      if (grant_q[i] !== 32'(i * 4)) $display("FAIL slow_addr: got %h required %h", grant_q[i], 32'(i * 4));
      else n_pass++;
    end
    n_checks++;
    if (consumed - c0 < 8) $display("FAIL slow_consumed: got %0d required >=8", consumed - c0);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit found;
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = if_valid;
    end
    n_checks++; if (!found) $display("FAIL stall_setup_timeout: valid=%b required 1", if_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc)
        $display("FAIL stall_hold: valid=%b pc=%h required 1 / %h", if_valid, if_pc, exp_pc);
      else n_pass++;
    end
    n_checks++; if (bus.req !== 1'b0) $display("FAIL stall_req_stop: req=%b required 0", bus.req); else n_pass++;
    cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== mem_word(exp_pc))
      $display("FAIL skid_drain: valid=%b pc=%h inst=%h required 1 / %h / %h", if_valid, if_pc, if_inst, exp_pc, mem_word(exp_pc));
    else n_pass++;
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = (grant_q.size() > 0) && (grant_q[grant_q.size() - 1] == 32'h8);
    end
    n_checks++; if (!found) $display("FAIL redir_setup_timeout: no grant at 0x8 required one"); else n_pass++;
    grant_q.delete();
    cycle(1'b1, 32'h100, 1'b0);
    n_checks++;
    if (if_valid !== 1'b0 || bus.req !== 1'b0)
      $display("FAIL redir_kill: valid=%b req=%b required 0 / 0", if_valid, bus.req);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = if_valid;
    end
    n_checks++;
    if (!found || if_pc !== 32'h100 || if_inst !== mem_word(32'h100))
      $display("FAIL redir_target: valid=%b pc=%h inst=%h required 1 / 100 / %h", if_valid, if_pc, if_inst, mem_word(32'h100));
    else n_pass++;
    n_checks++;
    if (grant_q.size() == 0) $display("FAIL redir_first_req: no request required addr 100");
    else if (grant_q[0] !== 32'h100) $display("FAIL redir_first_req: got %h required 100", grant_q[0]);
    else n_pass++;
  endtask

  task automatic test_redirect_rvalid_stall();
    bit found;
    do_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = if_valid;
    end
    n_checks++; if (!found) $display("FAIL rs_setup_timeout: valid=%b required 1", if_valid); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && wait_cnt == 0) found = 1'b1;
      else cycle(1'b0, 32'h0, 1'b1);
    end
    n_checks++; if (!found) $display("FAIL rs_resp_timeout: no response due required one"); else n_pass++;
    cycle(1'b1, 32'h300, 1'b1);
    n_checks++;
    if (if_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h300)
      $display("FAIL rs_redirect: valid=%b req=%b addr=%h required 0 / 1 / 300", if_valid, bus.req, bus.addr);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = if_valid;
    end
    n_checks++;
    if (!found || if_pc !== 32'h300)
      $display("FAIL rs_first_inst: valid=%b pc=%h required 1 / 300", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_misalign();
    bit found;
    do_reset();
    gnt_pct = 0; lat_min = 1; lat_max = 1;
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h102, 1'b0);
    n_checks++;
    if (MIS_EN) begin
      if (misalign !== 1'b1 || bus.req !== 1'b0)
        $display("FAIL mis_set: misalign=%b req=%b required 1 / 0", misalign, bus.req);
      else n_pass++;
    end else begin
      if (misalign !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h100)
        $display("FAIL mis_clear_bits: misalign=%b req=%b addr=%h required 0 / 1 / 100", misalign, bus.req, bus.addr);
      else n_pass++;
    end
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (misalign !== MIS_EN || bus.req !== !MIS_EN)
      $display("FAIL mis_sticky: misalign=%b req=%b required %b / %b", misalign, bus.req, MIS_EN, !MIS_EN);
    else n_pass++;
    cycle(1'b1, 32'h200, 1'b0);
    n_checks++;
    if (misalign !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 32'h200)
      $display("FAIL mis_recover: misalign=%b req=%b addr=%h required 0 / 1 / 200", misalign, bus.req, bus.addr);
    else n_pass++;
    gnt_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      found = if_valid;
    end
    n_checks++;
    if (!found || if_pc !== 32'h200)
      $display("FAIL mis_first_inst: valid=%b pc=%h required 1 / 200", if_valid, if_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    int          c0;
    logic        sel, stall;
    logic [31:0] tgt;
    do_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    c0 = consumed;
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(99) < 30);
      sel   = ($urandom_range(99) < 5);
      tgt   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_FFFC);
      cycle(sel, tgt, stall);
    end
    n_checks++;
    if (consumed - c0 < 100) $display("FAIL random_progress: consumed %0d required >=100", consumed - c0);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; pc_sel = 1'b0; alu_data = '0; id_stall = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    test_reset();
    test_sequential();
    test_slow_response();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
